fifo_param: RTL and testbench



---
 rtl/fifo_param_pkg.sv | 11 +
 rtl/memoria_param.sv | 32 +++
 rtl/fifo_param.sv | 92 +++++++++
 tb/tb_fifo_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared defaults and width helper for the parameterised FIFO and its storage.
package fifo_param_pkg;
  localparam int DEF_BITNUMBER = 10;
  localparam int DEF_LENGTH    = 8;
  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_MARGIN = 2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/memoria_param.sv
// Dual-pointer register array: one write port, one registered read port (latency 1).
module memoria_param
  import fifo_param_pkg::*;
#(
  parameter int BITNUMBER = DEF_BITNUMBER,
  parameter int LENGTH    = DEF_LENGTH,
  localparam int AW       = ptr_width(LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [AW-1:0]        ptr_write,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 read,
  input  logic [AW-1:0]        ptr_read,
  output logic [BITNUMBER-1:0] data_out
);
  logic [BITNUMBER-1:0] mem_q [LENGTH];
  logic [BITNUMBER-1:0] rd_q;

  // Array is deliberately not reset; only written words are ever read out.
  always_ff @(posedge clk) begin
    if (write) mem_q[ptr_write] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset)     rd_q <= '0;
    else if (read) rd_q <= mem_q[ptr_read];
  end

  assign data_out = rd_q;
endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO control: pointers, occupancy count, registered flags and sticky errors.
// Storage lives in memoria_param; read data appears one cycle after an accepted pop.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int BITNUMBER = DEF_BITNUMBER,
  parameter int LENGTH    = DEF_LENGTH,
  parameter int AF_THRESH = LENGTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int AW       = ptr_width(LENGTH),
  localparam int CW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 pop,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CW-1:0]        count,
  output logic                 overflow,
  output logic                 underflow
);
  logic [AW-1:0] ptr_wr_q, ptr_rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          valid_q, ovf_q, unf_q;
  logic          push_acc, pop_acc;

  assign pop_acc  = pop & ~empty_q;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign push_acc = push & (~full_q | pop_acc);

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (!push_acc && pop_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_wr_q <= '0;
      ptr_rd_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (push_acc) ptr_wr_q <= ptr_wr_q + AW'(1);
      if (pop_acc)  ptr_rd_q <= ptr_rd_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(LENGTH));
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= CW'(AF_THRESH));
      ae_q    <= (count_d <= CW'(AE_THRESH));
      valid_q <= pop_acc;
      if (push && full_q && !pop_acc) ovf_q <= 1'b1;
      if (pop && empty_q)             unf_q <= 1'b1;
    end
  end

  memoria_param #(
    .BITNUMBER(BITNUMBER),
    .LENGTH   (LENGTH)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .write    (push_acc & ~reset),
    .ptr_write(ptr_wr_q),
    .data_in  (data_in),
    .read     (pop_acc & ~reset),
    .ptr_read (ptr_rd_q),
    .data_out (data_out)
  );

  assign valid_out    = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param at default parameters (10-bit words, depth 8, AF=6, AE=2).
module tb_fifo_param;
  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_param dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1ns after the edge.
  task automatic cyc(input logic ps, input logic [9:0] d, input logic pp);
    push = ps; data_in = d; pop = pp;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset(input logic ps, input logic [9:0] d);
    reset = 1'b1; push = ps; data_in = d; pop = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; push = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".empty"}, 32'(empty), 1);
    check({tag, ".ae"},    32'(almost_empty), 1);
    check({tag, ".full"},  32'(full), 0);
    check({tag, ".af"},    32'(almost_full), 0);
    check({tag, ".valid"}, 32'(valid_out), 0);
    check({tag, ".dout"},  32'(data_out), 0);
    check({tag, ".ovf"},   32'(overflow), 0);
    check({tag, ".unf"},   32'(underflow), 0);
  endtask

  logic [9:0] q[$];
  logic [9:0] exp_w;

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    @(negedge clk);
    do_reset(1'b0, 10'h0);
    check_reset_state("rst0");

    // Fill to full, watching the threshold flags on every step.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 10'(i), 1'b0);
      check($sformatf("fill%0d.count", i), 32'(count), 32'(i));
      check($sformatf("fill%0d.af", i), 32'(almost_full), 32'(i >= 6));
      check($sformatf("fill%0d.ae", i), 32'(almost_empty), 32'(i <= 2));
      check($sformatf("fill%0d.full", i), 32'(full), 32'(i == 8));
    end
    cyc(1'b1, 10'h3AA, 1'b0);
    check("ovf.flag", 32'(overflow), 1);
    check("ovf.count", 32'(count), 8);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 10'h0, 1'b1);
      check($sformatf("drain%0d.dout", i), 32'(data_out), 32'(i));
      check($sformatf("drain%0d.valid", i), 32'(valid_out), 1);
      check($sformatf("drain%0d.count", i), 32'(count), 32'(8 - i));
    end
    check("drain.empty", 32'(empty), 1);
    cyc(1'b0, 10'h0, 1'b1);
    check("unf.flag", 32'(underflow), 1);
    check("unf.valid", 32'(valid_out), 0);
    check("unf.hold", 32'(data_out), 32'h8);
    check("ovf.sticky", 32'(overflow), 1);

    // Simultaneous push/pop at full, then at empty.
    do_reset(1'b0, 10'h0);
    check("rst1.ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 10'(16 + i), 1'b0);
    cyc(1'b1, 10'h3FF, 1'b1);
    check("fullpp.dout", 32'(data_out), 32'h10);
    check("fullpp.count", 32'(count), 8);
    check("fullpp.ovf", 32'(overflow), 0);
    check("fullpp.full", 32'(full), 1);
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 7) ? 10'(17 + i) : 10'h3FF;
      cyc(1'b0, 10'h0, 1'b1);
      check($sformatf("fulldrain%0d", i), 32'(data_out), 32'(exp_w));
    end
    cyc(1'b1, 10'h055, 1'b1);
    check("emptypp.count", 32'(count), 1);
    check("emptypp.unf", 32'(underflow), 1);
    check("emptypp.valid", 32'(valid_out), 0);
    check("emptypp.empty", 32'(empty), 0);
    cyc(1'b0, 10'h0, 1'b1);
    check("emptypp.dout", 32'(data_out), 32'h55);

    // Streaming at count=3; 23 pushes total wraps both pointers twice.
    do_reset(1'b0, 10'h0);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 10'(32 + i), 1'b0);
      q.push_back(10'(32 + i));
    end
    for (int k = 0; k < 20; k++) begin
      q.push_back(10'(48 + k));
      exp_w = q.pop_front();
      cyc(1'b1, 10'(48 + k), 1'b1);
      check($sformatf("stream%0d.dout", k), 32'(data_out), 32'(exp_w));
      check($sformatf("stream%0d.count", k), 32'(count), 3);
    end

    // Reset while pushing at count=5: the pushed word must be discarded.
    do_reset(1'b0, 10'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 10'(64 + i), 1'b0);
    check("pre_rst.count", 32'(count), 5);
    do_reset(1'b1, 10'h077);
    check_reset_state("rst2");
    cyc(1'b1, 10'h001, 1'b0);
    cyc(1'b0, 10'h0, 1'b1);
    check("post_rst.dout", 32'(data_out), 32'h1);
    check("post_rst.count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
